char_stream_arbiter: RTL

Two-requester, round-robin arbiter that shares one N-bit character output path between two producers in the Morse-to-ASCII design, e.g. the decoded-character stream and the separator/space generator. It drives the select of an internal N-bit 2:1 multiplexer and captures the chosen character in a one-entry output register. Every port uses valid/ready handshakes. The registered output feeds the downstream display/UART stage.

---
 rtl/char_stream_arbiter.sv | 90 +++++++++
 1 files changed

// File: rtl/char_stream_arbiter.sv
// Round-robin arbiter sharing one registered N-bit character output between
// two valid/ready producers; the grant also drives the internal 2:1 data mux.
module char_stream_arbiter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in0_valid,
  input  logic [N-1:0] in0_data,
  output logic         in0_ready,
  input  logic         in1_valid,
  input  logic [N-1:0] in1_data,
  output logic         in1_ready,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  output logic         out_src,
  input  logic         out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t       state_p1;
  state_t       state_d;
  logic [N-1:0] data_p1;
  logic         src_p1;
  logic         last_p1;

  logic         load;
  logic         any_valid;
  logic         pick;
  logic         grant;
  logic [N-1:0] mux_data;

  // Ties go to the channel that did not win most recently.
  function automatic logic pick_channel(input logic v0, input logic v1,
                                        input logic last);
    if (v0 && v1) begin
      return ~last;
    end
    return v1;
  endfunction

  // Stage p0: arbitration and data select (combinational, data-independent readies)
  always_comb begin
    state_d   = state_p1;
    load      = 1'b0;
    any_valid = in0_valid | in1_valid;
    pick      = pick_channel(in0_valid, in1_valid, last_p1);
    grant     = 1'b0;
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    mux_data  = in0_data;

    load  = (state_p1 == EMPTY) || out_ready;
    grant = load && any_valid && !reset;

    in0_ready = grant && !pick;
    in1_ready = grant && pick;
    mux_data  = pick ? in1_data : in0_data;

    if (load) begin
      state_d = any_valid ? FULL : EMPTY;
    end
  end

  // Stage p1: one-entry output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p1 <= EMPTY;
      data_p1  <= '0;
      src_p1   <= 1'b0;
      last_p1  <= 1'b1;
    end else begin
      state_p1 <= state_d;
      if (grant) begin
        data_p1 <= mux_data;
        src_p1  <= pick;
        last_p1 <= pick;
      end
    end
  end

  assign out_valid = (state_p1 == FULL);
  assign out_data  = data_p1;
  assign out_src   = src_p1;

endmodule
